// File: rtl/adc_sched_pkg.sv
// Shared types and widths for the ADC conversion scheduler.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    RESPOND = 2'd3
  } sched_state_t;

  localparam int SAMPLE_CNT_W = 4;
  localparam int WDOG_W       = 8;

endpackage

// File: rtl/adc_conversion_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_i and wraps around.
// The one-hot grant and the encoded index are both combinational.
module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/adc_conversion_scheduler.sv
// Shares one SAR ADC controller among NUM_REQ requesters: holds it in sampling,
// releases it for one conversion, and returns the result with a watchdog abort.
//
// state   | meaning
// IDLE    | ADC held in reset, arbitrating requests
// SAMPLE  | ADC held in reset for sample_cycles+1 cycles
// CONVERT | ADC released, waiting for the finished strobe or the watchdog
// RESPOND | result presented until the consumer accepts it
module adc_conversion_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MATRIX_BITS    = 12,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_avg_control,
  input  logic [4*NUM_REQ-1:0]   req_sample_cycles,
  output logic                   adc_rst_n,
  output logic [2:0]             adc_avg_control,
  input  logic                   adc_conv_finished_strobe_in,
  input  logic [MATRIX_BITS-1:0] adc_result_in,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [MATRIX_BITS-1:0] rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_timeout,
  output logic                   busy
);

  sched_state_t            state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [2:0]              avg_q, avg_d;
  logic [SAMPLE_CNT_W-1:0] scnt_q, scnt_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    adc_rst_n_q, adc_rst_n_d;
  logic [MATRIX_BITS-1:0]  data_q, data_d;
  logic                    tmo_q, tmo_d;

  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      avg_q       <= '0;
      scnt_q      <= '0;
      wdog_q      <= '0;
      adc_rst_n_q <= 1'b0;
      data_q      <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      avg_q       <= avg_d;
      scnt_q      <= scnt_d;
      wdog_q      <= wdog_d;
      adc_rst_n_q <= adc_rst_n_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    avg_d       = avg_q;
    scnt_d      = scnt_q;
    wdog_d      = wdog_q;
    adc_rst_n_d = adc_rst_n_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        adc_rst_n_d = 1'b0;
        if (|gnt) begin
          id_d     = gnt_idx;
          avg_d    = req_avg_control[3*int'(gnt_idx) +: 3];
          scnt_d   = req_sample_cycles[4*int'(gnt_idx) +: 4];
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
          state_d  = SAMPLE;
        end
      end
      SAMPLE: begin
        if (scnt_q == '0) begin
          adc_rst_n_d = 1'b1;
          wdog_d      = WDOG_W'(TIMEOUT_CYCLES-1);
          state_d     = CONVERT;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      CONVERT: begin
        // Strobe is checked first so it wins over a same-cycle watchdog expiry.
        if (adc_conv_finished_strobe_in) begin
          data_d      = adc_result_in;
          tmo_d       = 1'b0;
          adc_rst_n_d = 1'b0;
          state_d     = RESPOND;
        end else if (wdog_q == '0) begin
          data_d      = '0;
          tmo_d       = 1'b1;
          adc_rst_n_d = 1'b0;
          state_d     = RESPOND;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready       = gnt;
  assign adc_rst_n       = adc_rst_n_q;
  assign adc_avg_control = (state_q == IDLE) ? 3'd0 : avg_q;
  assign rsp_valid       = (state_q == RESPOND);
  assign rsp_data        = data_q;
  assign rsp_id          = id_q;
  assign rsp_timeout     = tmo_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Randomized transaction-level bench for adc_conversion_scheduler with a
// behavioural ADC model and a round-robin/latency reference model.
module tb_adc_conversion_scheduler;

  localparam int NREQ = 4;
  localparam int MB   = 12;
  localparam int TO   = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [3*NREQ-1:0] req_avg_control;
  logic [4*NREQ-1:0] req_sample_cycles;
  logic            adc_rst_n;
  logic [2:0]      adc_avg_control;
  logic            strobe;
  logic [MB-1:0]   adc_result_in;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [MB-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_timeout;
  logic            busy;

  always #5 clk = ~clk;

  adc_conversion_scheduler #(
    .NUM_REQ        (NREQ),
    .MATRIX_BITS    (MB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .req_valid                   (req_valid),
    .req_ready                   (req_ready),
    .req_avg_control             (req_avg_control),
    .req_sample_cycles           (req_sample_cycles),
    .adc_rst_n                   (adc_rst_n),
    .adc_avg_control             (adc_avg_control),
    .adc_conv_finished_strobe_in (strobe),
    .adc_result_in               (adc_result_in),
    .rsp_valid                   (rsp_valid),
    .rsp_ready                   (rsp_ready),
    .rsp_data                    (rsp_data),
    .rsp_id                      (rsp_id),
    .rsp_timeout                 (rsp_timeout),
    .busy                        (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ADC model: strobe in the lat-th released cycle; stray strobes while held.
  int adc_lat   = 255;
  bit adc_stray = 1'b0;
  int conv_cnt  = 0;

  initial begin
    strobe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (adc_rst_n) begin
        conv_cnt++;
        strobe = (conv_cnt == adc_lat);
      end else begin
        conv_cnt = 0;
        strobe   = adc_stray;
      end
    end
  end

  int         exp_ptr = 0;
  logic [2:0] f_avg[NREQ];
  logic [3:0] f_scyc[NREQ];

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      f_avg[i]  = 3'($urandom);
      f_scyc[i] = 4'($urandom);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_avg_control[3*i +: 3]   = f_avg[i];
      req_sample_cycles[4*i +: 4] = f_scyc[i];
    end
  endtask

  // One complete transaction; caller sets f_avg/f_scyc beforehand.
  task automatic run_txn(input logic [NREQ-1:0] mask, input int lat, input int hold,
                         input bit stray, input logic [MB-1:0] val);
    int id, n, c;
    logic [2:0] e_avg;
    logic [3:0] e_s;
    logic [MB-1:0] e_data;
    bit e_to, bad_rdy, bad_avg, bad_hold;
    logic [31:0] snap;
    adc_lat = lat;
    adc_stray = stray;
    adc_result_in = val;
    @(negedge clk);
    req_valid = mask;
    drive_fields();
    id = rr_pick(mask, exp_ptr);
    e_avg = f_avg[id];
    e_s = f_scyc[id];
    #1;
    chk("grant", 32'(req_ready), 32'(1) << id);
    chk("idle_out", {busy, adc_rst_n, adc_avg_control}, 0);
    exp_ptr = (id + 1) % NREQ;
    bad_rdy = 0;
    bad_avg = 0;
    n = 0;
    rand_fields();
    @(negedge clk);
    drive_fields();
    #1;
    chk("avg_sample", adc_avg_control, e_avg);
    while (!adc_rst_n && n < 40) begin
      n++;
      if (req_ready != 0) bad_rdy = 1;
      @(negedge clk);
      #1;
    end
    chk("sample_len", n, int'(e_s) + 1);
    c = 0;
    while (adc_rst_n && c < 300) begin
      c++;
      if (adc_avg_control != e_avg) bad_avg = 1;
      if (req_ready != 0) bad_rdy = 1;
      @(negedge clk);
      #1;
    end
    e_to = (lat > TO);
    e_data = e_to ? '0 : val;
    chk("conv_len", c, e_to ? TO : lat);
    chk("avg_hold", bad_avg, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_id", rsp_id, id);
    chk("rsp_timeout", rsp_timeout, e_to);
    snap = 32'({rsp_valid, rsp_timeout, rsp_id, rsp_data, adc_rst_n, req_ready});
    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      if (32'({rsp_valid, rsp_timeout, rsp_id, rsp_data, adc_rst_n, req_ready}) != snap)
        bad_hold = 1;
    end
    if (hold > 0) chk("bp_hold", bad_hold, 0);
    chk("no_grant_busy", bad_rdy, 0);
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("back_idle", {busy, rsp_valid, adc_rst_n}, 0);
  endtask

  task automatic run_reset_mid();
    int n;
    adc_lat = 255;
    adc_stray = 1'b0;
    rand_fields();
    @(negedge clk);
    req_valid = 4'b0110;
    drive_fields();
    #1;
    chk("rst_grant_seen", |req_ready, 1);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    #1;
    while (!adc_rst_n && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_convert", adc_rst_n, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_adc_rst_n", adc_rst_n, 0);
    chk("rst_outs", {rsp_valid, busy, adc_avg_control, rsp_data, rsp_id, rsp_timeout, req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, sel;
    rst_n = 1'b0;
    req_valid = '0;
    req_avg_control = '0;
    req_sample_cycles = '0;
    rsp_ready = 1'b0;
    adc_result_in = '0;
    #1;
    chk("reset_outs", {adc_rst_n, req_ready, rsp_valid, rsp_data, rsp_id, rsp_timeout, busy, adc_avg_control}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single request: requester 2, avg 0, S=3, result 0x5A3
    rand_fields();
    f_avg[2] = 3'd0;
    f_scyc[2] = 4'd3;
    run_txn(4'b0100, 18, 0, 1'b0, 12'h5A3);

    run_reset_mid();

    // round robin with all requesters active: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      run_txn(4'b1111, 18, 1, 1'b0, 12'($urandom));
    end

    // backpressure
    rand_fields();
    run_txn(4'b1010, 18, 10, 1'b0, 12'($urandom));

    // timeout followed by a normal conversion
    rand_fields();
    run_txn(4'b0001, 255, 0, 1'b0, 12'($urandom));
    rand_fields();
    run_txn(4'b0001, 18, 0, 1'b0, 12'($urandom));

    // strobe on the last watchdog cycle, one cycle late, and stray strobes
    rand_fields();
    run_txn(4'b1000, TO, 0, 1'b0, 12'($urandom));
    rand_fields();
    run_txn(4'b1000, TO + 1, 0, 1'b0, 12'($urandom));
    rand_fields();
    run_txn(4'b0010, 5, 2, 1'b1, 12'($urandom));

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: lat = 255;
        1: lat = TO;
        2: lat = TO + 1;
        default: lat = int'($urandom_range(1, TO + 4));
      endcase
      rand_fields();
      run_txn(4'($urandom_range(1, 15)), lat, int'($urandom_range(0, 3)),
              1'($urandom), 12'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_conversion_scheduler.md
# adc_conversion_scheduler

Schedules single SAR conversions on one `adc_control_nonbinary` instance and shares it among `NUM_REQ` requesters. The block holds the ADC controller in reset, which keeps it in sampling, for a per-request number of cycles. It then releases the controller, captures the result on the finished strobe and returns it with the requester ID over a valid/ready response port. A watchdog aborts conversions that never finish.

## Interface
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `MATRIX_BITS`, 12: ADC result width.
- `TIMEOUT_CYCLES`, 200: maximum number of CONVERT cycles before abort; must be 1..255.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID; this is a derived parameter and is not overridden.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: conversion request, one bit per requester.
- `req_ready` out `NUM_REQ`: grant, one-hot, asserted only in IDLE.
- `req_avg_control` in `3*NUM_REQ`: averaging code per requester; requester i uses bits [3i+2:3i].
- `req_sample_cycles` in `4*NUM_REQ`: extra sampling cycles per requester.
- `adc_rst_n` out 1: drives the ADC controller `rst_n`; comes directly from a flop.
- `adc_avg_control` out 3: drives the ADC `avg_control_in`.
- `adc_conv_finished_strobe_in` in 1: ADC finished strobe.
- `adc_result_in` in `MATRIX_BITS`: ADC `result_out`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted by the consumer.
- `rsp_data` out `MATRIX_BITS`: conversion result.
- `rsp_id` out `ID_W`: ID of the requester that owns the response.
- `rsp_timeout` out 1: set when the conversion was aborted by the watchdog.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE → SAMPLE → CONVERT → RESPOND → IDLE.
- **IDLE**
  - `adc_rst_n`=0.
  - Round-robin arbitration over `req_valid`. The search starts at `rr_ptr`, which resets to 0.
  - If any request is valid, the selected requester gets `req_ready[i]`=1 combinationally in the same cycle, and that cycle is the handshake.
  - On the handshake the block latches the ID, `avg_control` and `sample_cycles`, sets `rr_ptr` to (i+1) mod `NUM_REQ`, and goes to SAMPLE.
- **SAMPLE**
  - `adc_rst_n`=0, so the ADC sits in its sampling state.
  - `adc_avg_control` shows the latched code.
  - Lasts `sample_cycles`+1 cycles, counted by a 4-bit down-counter.
  - Then `adc_rst_n`←1 and the block goes to CONVERT.
- **CONVERT**
  - `adc_rst_n`=1.
  - `adc_avg_control` is held stable, because the ADC samples it in its first released cycle.
  - An 8-bit watchdog counts CONVERT cycles.
  - Strobe=1: capture `adc_result_in`, clear `rsp_timeout`, set `adc_rst_n`←0, go to RESPOND.
  - Watchdog reaches `TIMEOUT_CYCLES` with no strobe: `rsp_data`←0, `rsp_timeout`←1, `adc_rst_n`←0, go to RESPOND.
  - Strobe and timeout in the same cycle: the strobe wins.
- **RESPOND**
  - `rsp_valid`=1.
  - `rsp_data`, `rsp_id` and `rsp_timeout` are held stable until `rsp_ready`.
  - `rsp_valid`&`rsp_ready`: go to IDLE.
- A strobe outside CONVERT is ignored.
- Requester inputs are sampled only at the handshake; changes after grant have no effect.
- `adc_avg_control` shows 0 in IDLE.
- Reset values: `adc_rst_n`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_timeout`=0, `busy`=0, `adc_avg_control`=0. State is IDLE and `rr_ptr`=0.
- Reset mid-operation: everything returns to the reset values at once. Any pending response is lost, and the ADC is forced back to sampling.

## Timing
- Handshake at cycle T.
- SAMPLE covers cycles T+1 .. T+1+S, where S is `sample_cycles`. `adc_rst_n` rises at the edge that ends cycle T+1+S.
- An ADC conversion without averaging finishes in 18 cycles. `TIMEOUT_CYCLES` must cover the averaging worst case, about 140 cycles.
- Strobe seen at cycle C: `rsp_valid`=1 from C+1, and `adc_rst_n`=0 from C+1. The ADC never starts a second, unrequested conversion that gets captured.
- Minimum request-to-request period with `rsp_ready` tied high: 1 (IDLE) + (S+1) + conversion + 1 (RESPOND).
- No combinational path from `rsp_ready` to `req_ready`. Next grant is at the earliest in the IDLE cycle after the response is accepted.

## Structure
- Package `adc_sched_pkg` holds:
  - the state enum `sched_state_t` with IDLE, SAMPLE, CONVERT and RESPOND;
  - the sample-counter width (4) and watchdog width (8) constants.
- One sub-module, `rr_arbiter`, is parameterised by `NUM_REQ`:
  - inputs: request vector, pointer and enable;
  - outputs: one-hot grant and encoded index, both combinational.
- Everything else lives in the top module.

## Test plan
- **Single request.** Requester 2 with avg=0 and S=3, ADC model returning 0x5A3 → `adc_rst_n` low for 4 SAMPLE cycles. Then `rsp_valid` with `rsp_data`=0x5A3, `rsp_id`=2, `rsp_timeout`=0, the cycle after the strobe.
- **Round robin.** All 4 `req_valid` held high → grant order 0,1,2,3,0. Each grant appears only after the previous response is accepted.
- **Backpressure.** `rsp_ready` held low for 10 cycles → `rsp_valid`, data and ID held stable. No new `req_ready` until acceptance. `adc_rst_n` stays 0.
- **Timeout.** Strobe suppressed with `TIMEOUT_CYCLES`=20 → response after 20 CONVERT cycles with `rsp_timeout`=1 and `rsp_data`=0. A following normal conversion succeeds.
- **Stray strobe and simultaneous events.** Strobe pulsed in IDLE/SAMPLE → ignored. Strobe coincides with the last timeout cycle → `rsp_timeout`=0 and the ADC result is returned.
- **Reset mid-CONVERT.** `rst_n` pulsed low during CONVERT → `adc_rst_n`=0 immediately and `rsp_valid`=0. The next grant goes to requester 0.
